fc_layer_sequencer: RTL and testbench
=====================================

# fc_layer_sequencer

Sequences one fully-connected layer through a single external `vector_dot_product` MAC. It walks the input-activation memory and the weight memory for each output neuron and drives the MAC's `valid_in`/`sop`/`eop`/`data_a`/`data_b`. It collects each 32-bit dot product and writes it to the output memory. It sits between the layer-level control FSM (start/done) and the shared MAC plus the three on-chip RAMs.

## Interface

Parameters:
- `IN_LEN`, 784: vector length per neuron (≥1)
- `OUT_LEN`, 10: number of output neurons (≥1)
- `IN_AW`, `$clog2(IN_LEN)` (min 1): input address width
- `W_AW`, `$clog2(IN_LEN*OUT_LEN)` (min 1): weight address width
- `OUT_AW`, `$clog2(OUT_LEN)` (min 1): output address width

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to process the layer; sampled only in IDLE
- `busy`  out  1  high from the cycle after start is accepted until `done`
- `done`  out  1  one-cycle pulse after the last output write
- `in_addr`  out  IN_AW  input RAM address; sync read, 1-cycle latency
- `in_rdata`  in  8 signed  input RAM data
- `w_addr`  out  W_AW  weight RAM address; sync read, 1-cycle latency
- `w_rdata`  in  8 signed  weight RAM data
- `mac_valid`, `mac_sop`, `mac_eop`  out  1 each  to MAC `valid_in`/`sop`/`eop`
- `mac_a`, `mac_b`  out  8 signed each  to MAC `data_a`/`data_b`; combinational from `in_rdata`/`w_rdata`
- `mac_result`  in  32 signed  MAC `result`
- `mac_result_valid`  in  1  MAC `result_valid`; asserted 2 cycles after the `mac_valid` carrying `mac_eop`
- `out_we`  out  1  output RAM write strobe
- `out_addr`  out  OUT_AW  neuron index being written
- `out_data`  out  32 signed  value written

## Operation

- FSM states: IDLE, RUN, WAIT, WRITE.
  - IDLE: `start` → RUN, neuron counter n=0, element counter i=0, weight pointer wp=0.
  - RUN: one cycle per element. Drive `in_addr`=i and `w_addr`=wp, then i++ and wp++. When i=IN_LEN-1 → WAIT.
  - WAIT: hold until `mac_result_valid`. Capture `mac_result` and go to WRITE.
  - WRITE: `out_we`=1, `out_addr`=n, `out_data`=captured value. If n=OUT_LEN-1 → IDLE and pulse `done`; else n++, i=0, → RUN. wp carries over and is not reset.
- Issue side-band: `mac_valid`/`mac_sop`/`mac_eop` are RUN-cycle flags (i==0, i==IN_LEN-1) delayed one register stage to align with the RAM read data.
- IN_LEN=1: `mac_sop` and `mac_eop` are asserted in the same cycle.
- `start` while busy: ignored. `mac_result_valid` outside WAIT: ignored.
- Reset (any state, including mid-layer): the next state is IDLE. All counters and outputs are zeroed. In-flight MAC output is discarded.

## Timing

- Reset values: `busy`, `done`, `mac_valid`, `mac_sop`, `mac_eop`, `out_we` = 0. `in_addr`, `w_addr`, `out_addr`, `out_data` = 0.
- Cycle-by-cycle, relative to start accepted at cycle 0:
  - Neuron 0 RUN occupies cycles 1..IN_LEN.
  - `mac_valid` is high for cycles 2..IN_LEN+1.
  - `mac_result_valid` arrives at cycle IN_LEN+3.
  - `out_we` is high at cycle IN_LEN+4.
- Per-neuron period: IN_LEN+4 cycles.
- `done` is asserted at cycle 1+OUT_LEN·(IN_LEN+4). `busy` falls in that same cycle.
- `mac_valid` is never asserted in two consecutive neurons without a gap of at least 3 cycles.

## Configuration

- `FC_RELU_EN` defined: the WRITE stage applies ReLU. Negative captured results are written as 0; non-negative results pass unchanged.
- `FC_RELU_EN` undefined: the raw signed 32-bit dot product is written.

## Test plan

- IN_LEN=4, OUT_LEN=2, in=[1,2,3,4], w0=[1,1,1,1], w1=[-1,-2,-3,-4], start at cycle 0.
  - Expected: writes (0,10) at cycle 8 and (1,-30) at cycle 16; `done` at cycle 17.
  - With `FC_RELU_EN`: the second write is 0.
- IN_LEN=1, OUT_LEN=3, in=[-128], w=[-128,127,0].
  - Expected: `mac_sop`=`mac_eop`=1 on each issue; writes 16384, -16256, 0; `done` at cycle 16.
- `start` pulsed again at cycle 5 of a run: no restart, identical write sequence, exactly one `done`.
- `rst` asserted at cycle 6 of a run: the next cycle has all outputs 0 and the FSM in IDLE. A fresh `start` then produces the full correct result set.
- Back-to-back layers: `start` asserted the cycle after `done` is accepted, and the second run's timing is identical to the first.
- Checker: `w_addr` sequence is 0..IN_LEN·OUT_LEN-1 exactly once. `in_addr` cycles 0..IN_LEN-1 per neuron.

Source files
------------

// File: rtl/fc_layer_sequencer.sv
// Streams one fully-connected layer through a shared dot-product MAC and writes each neuron result.
// Optional build macro FC_RELU_EN: clamp negative results to zero before the output write.
module fc_layer_sequencer #(
    parameter int IN_LEN  = 784,
    parameter int OUT_LEN = 10,
    parameter int IN_AW   = (IN_LEN > 1) ? $clog2(IN_LEN) : 1,
    parameter int W_AW    = (IN_LEN * OUT_LEN > 1) ? $clog2(IN_LEN * OUT_LEN) : 1,
    parameter int OUT_AW  = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [IN_AW-1:0]         in_addr,
    input  logic signed [7:0]        in_rdata,
    output logic [W_AW-1:0]          w_addr,
    input  logic signed [7:0]        w_rdata,
    output logic                     mac_valid,
    output logic                     mac_sop,
    output logic                     mac_eop,
    output logic signed [7:0]        mac_a,
    output logic signed [7:0]        mac_b,
    input  logic signed [31:0]       mac_result,
    input  logic                     mac_result_valid,
    output logic                     out_we,
    output logic [OUT_AW-1:0]        out_addr,
    output logic signed [31:0]       out_data
);

    typedef enum logic [1:0] {IDLE, RUN, WAIT, WRITE} state_t;

    localparam logic [IN_AW-1:0]  I_LAST = IN_AW'(IN_LEN - 1);
    localparam logic [OUT_AW-1:0] N_LAST = OUT_AW'(OUT_LEN - 1);

    state_t              state;
    logic [IN_AW-1:0]    i;
    logic [W_AW-1:0]     wp;
    logic [OUT_AW-1:0]   n;

    // Addresses come straight from the counters; RAM data lands one cycle later,
    // which is why the side-band flags below are registered once.
    assign in_addr = i;
    assign w_addr  = wp;
    assign mac_a   = in_rdata;
    assign mac_b   = w_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            i         <= '0;
            wp        <= '0;
            n         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mac_valid <= 1'b0;
            mac_sop   <= 1'b0;
            mac_eop   <= 1'b0;
            out_we    <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            done      <= 1'b0;
            out_we    <= 1'b0;
            mac_valid <= (state == RUN);
            mac_sop   <= (state == RUN) && (i == '0);
            mac_eop   <= (state == RUN) && (i == I_LAST);
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        i     <= '0;
                        wp    <= '0;
                        n     <= '0;
                    end
                end
                RUN: begin
                    wp <= wp + W_AW'(1);
                    if (i == I_LAST) begin
                        i     <= '0;
                        state <= WAIT;
                    end else begin
                        i <= i + IN_AW'(1);
                    end
                end
                WAIT: begin
                    if (mac_result_valid) begin
`ifdef FC_RELU_EN
                        out_data <= mac_result[31] ? '0 : mac_result;
`else
                        out_data <= mac_result;
`endif
                        out_addr <= n;
                        out_we   <= 1'b1;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    // wp is deliberately left running: weights are stored neuron-major.
                    if (n == N_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        n     <= n + OUT_AW'(1);
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Bench for fc_layer_sequencer: two instances (4x2 and 1x3) with RAM and MAC models.
module tb_fc_layer_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] st, busy_v, done_v, mval_v, sop_v, eop_v, we_v, resv_v;
    logic [1:0][7:0]  a_v, b_v, in_rdata_v, w_rdata_v;
    logic [1:0][31:0] res_v, od_v;
    logic [1:0] a0_in;  logic [2:0] a0_w;  logic [0:0] a0_out;
    logic [0:0] a1_in;  logic [1:0] a1_w;  logic [1:0] a1_out;
    logic signed [7:0] mem_in [2][4];
    logic signed [7:0] mem_w  [2][8];
    int acc [2];
    int p_d [2];
    logic [1:0] p_v;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fc_layer_sequencer #(.IN_LEN(4), .OUT_LEN(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .busy(busy_v[0]), .done(done_v[0]),
        .in_addr(a0_in), .in_rdata(in_rdata_v[0]), .w_addr(a0_w), .w_rdata(w_rdata_v[0]),
        .mac_valid(mval_v[0]), .mac_sop(sop_v[0]), .mac_eop(eop_v[0]),
        .mac_a(a_v[0]), .mac_b(b_v[0]), .mac_result(res_v[0]), .mac_result_valid(resv_v[0]),
        .out_we(we_v[0]), .out_addr(a0_out), .out_data(od_v[0]));

    fc_layer_sequencer #(.IN_LEN(1), .OUT_LEN(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .busy(busy_v[1]), .done(done_v[1]),
        .in_addr(a1_in), .in_rdata(in_rdata_v[1]), .w_addr(a1_w), .w_rdata(w_rdata_v[1]),
        .mac_valid(mval_v[1]), .mac_sop(sop_v[1]), .mac_eop(eop_v[1]),
        .mac_a(a_v[1]), .mac_b(b_v[1]), .mac_result(res_v[1]), .mac_result_valid(resv_v[1]),
        .out_we(we_v[1]), .out_addr(a1_out), .out_data(od_v[1]));

    function automatic int len_of(input int k);  return (k == 0) ? 4 : 1; endfunction
    function automatic int outn_of(input int k); return (k == 0) ? 2 : 3; endfunction
    function automatic int in_addr_of(input int k);  return (k == 0) ? int'(a0_in)  : int'(a1_in);  endfunction
    function automatic int w_addr_of(input int k);   return (k == 0) ? int'(a0_w)   : int'(a1_w);   endfunction
    function automatic int out_addr_of(input int k); return (k == 0) ? int'(a0_out) : int'(a1_out); endfunction
    function automatic int prod_of(input int k);
        return int'($signed(a_v[k])) * int'($signed(b_v[k]));
    endfunction

    // Sync-read RAMs plus a MAC that answers two cycles after the eop beat.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            in_rdata_v[k] <= mem_in[k][in_addr_of(k) & 3];
            w_rdata_v[k]  <= mem_w[k][w_addr_of(k) & 7];
            if (rst) begin
                acc[k] <= 0; p_v[k] <= 1'b0; p_d[k] <= 0;
                resv_v[k] <= 1'b0; res_v[k] <= '0;
            end else begin
                if (mval_v[k]) acc[k] <= (sop_v[k] ? 0 : acc[k]) + prod_of(k);
                p_v[k]    <= mval_v[k] & eop_v[k];
                p_d[k]    <= (sop_v[k] ? 0 : acc[k]) + prod_of(k);
                resv_v[k] <= p_v[k];
                res_v[k]  <= 32'(p_d[k]);
            end
        end
    end

    task automatic check_zero(input int k, input string nm);
        n_chk++;
        if ({busy_v[k], done_v[k], mval_v[k], sop_v[k], eop_v[k], we_v[k]} !== 6'b0 ||
            in_addr_of(k) != 0 || w_addr_of(k) != 0 || out_addr_of(k) != 0 || od_v[k] !== 32'd0) begin
            n_fail++;
            $display("FAIL %s: got busy=%b done=%b valid=%b sop=%b eop=%b we=%b in=%0d w=%0d oa=%0d od=%0d, want all 0",
                     nm, busy_v[k], done_v[k], mval_v[k], sop_v[k], eop_v[k], we_v[k],
                     in_addr_of(k), w_addr_of(k), out_addr_of(k), od_v[k]);
        end
    endtask

    // Runs one layer and checks it against sums computed straight from the memories.
    task automatic run_layer(input int k, input string nm, input bit pre, input int extra, input bit chain);
        int L = len_of(k);
        int O = outn_of(k);
        int dexp = 1 + O * (L + 4);
        int ndone = 0, done_at = -1, busy_err = 0, prev_in, prev_w;
        int wcyc[$], waddr[$], wdat[$];
        int icyc[$], ia[$], ib[$], isop[$], ieop[$], iin[$], iw[$];
        if (!pre) begin @(negedge clk); st[k] = 1'b1; end
        prev_in = in_addr_of(k);
        prev_w  = w_addr_of(k);
        for (int r = 1; r <= dexp + 4; r++) begin
            @(negedge clk);
            st[k] = (r == extra);
            if (busy_v[k] !== ((r < dexp) ? 1'b1 : 1'b0)) busy_err++;
            if (we_v[k]) begin
                wcyc.push_back(r); waddr.push_back(out_addr_of(k)); wdat.push_back(int'($signed(od_v[k])));
            end
            if (mval_v[k]) begin
                icyc.push_back(r); ia.push_back(int'($signed(a_v[k]))); ib.push_back(int'($signed(b_v[k])));
                isop.push_back(int'(sop_v[k])); ieop.push_back(int'(eop_v[k]));
                iin.push_back(prev_in); iw.push_back(prev_w);
            end
            if (done_v[k]) begin ndone++; if (done_at < 0) done_at = r; end
            prev_in = in_addr_of(k);
            prev_w  = w_addr_of(k);
            if (chain && r == dexp) begin st[k] = 1'b1; break; end
        end
        n_chk++;
        if (ndone !== 1 || done_at !== dexp) begin
            n_fail++;
            $display("FAIL %s done: got %0d pulses first at %0d, want 1 at %0d", nm, ndone, done_at, dexp);
        end
        n_chk++;
        if (busy_err !== 0) begin
            n_fail++;
            $display("FAIL %s busy: got %0d wrong cycles, want 0", nm, busy_err);
        end
        n_chk++;
        if (wcyc.size() !== O || icyc.size() !== L * O) begin
            n_fail++;
            $display("FAIL %s counts: got %0d writes %0d issues, want %0d and %0d",
                     nm, wcyc.size(), icyc.size(), O, L * O);
        end
        for (int n = 0; n < O && n < wcyc.size(); n++) begin
            int s = 0;
            for (int i = 0; i < L; i++) s += int'(mem_in[k][i]) * int'(mem_w[k][n * L + i]);
`ifdef FC_RELU_EN
            if (s < 0) s = 0;
`endif
            n_chk++;
            if (wcyc[n] !== (n + 1) * (L + 4) || waddr[n] !== n || wdat[n] !== s) begin
                n_fail++;
                $display("FAIL %s write%0d: got cyc=%0d addr=%0d data=%0d, want cyc=%0d addr=%0d data=%0d",
                         nm, n, wcyc[n], waddr[n], wdat[n], (n + 1) * (L + 4), n, s);
            end
        end
        for (int j = 0; j < L * O && j < icyc.size(); j++) begin
            int n = j / L;
            int i = j % L;
            int ec = 2 + n * (L + 4) + i;
            n_chk++;
            if (icyc[j] !== ec || ia[j] !== int'(mem_in[k][i]) || ib[j] !== int'(mem_w[k][n * L + i]) ||
                isop[j] !== int'(i == 0) || ieop[j] !== int'(i == L - 1) || iin[j] !== i || iw[j] !== n * L + i) begin
                n_fail++;
                $display("FAIL %s issue%0d: got cyc=%0d a=%0d b=%0d sop=%0d eop=%0d in=%0d w=%0d, want %0d %0d %0d %0d %0d %0d %0d",
                         nm, j, icyc[j], ia[j], ib[j], isop[j], ieop[j], iin[j], iw[j],
                         ec, mem_in[k][i], mem_w[k][n * L + i], int'(i == 0), int'(i == L - 1), i, n * L + i);
            end
        end
    endtask

    task automatic randomize_mem(input int k);
        for (int i = 0; i < 4; i++) mem_in[k][i] = 8'($urandom);
        for (int i = 0; i < 8; i++) mem_w[k][i]  = 8'($urandom);
    endtask

    task automatic test_reset();
        check_zero(0, "reset0");
        check_zero(1, "reset1");
    endtask

    task automatic test_directed();
        mem_in[0] = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
        mem_w[0]  = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, -8'sd1, -8'sd2, -8'sd3, -8'sd4};
        run_layer(0, "directed_4x2", 1'b0, -1, 1'b0);
        mem_in[1] = '{-8'sd128, 8'sd0, 8'sd0, 8'sd0};
        mem_w[1]  = '{-8'sd128, 8'sd127, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
        run_layer(1, "directed_1x3", 1'b0, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            randomize_mem(0);
            run_layer(0, "random_4x2", 1'b0, -1, 1'b0);
        end
        for (int t = 0; t < 2; t++) begin
            randomize_mem(1);
            run_layer(1, "random_1x3", 1'b0, -1, 1'b0);
        end
    endtask

    task automatic test_start_while_busy();
        randomize_mem(0);
        run_layer(0, "restart_ignored", 1'b0, 5, 1'b0);
    endtask

    task automatic test_reset_mid();
        int act = 0;
        randomize_mem(0);
        @(negedge clk); st[0] = 1'b1;
        for (int r = 1; r <= 6; r++) begin
            @(negedge clk);
            st[0] = 1'b0;
            if (r == 6) rst = 1'b1;
        end
        @(negedge clk);
        check_zero(0, "reset_mid");
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy_v[0] || mval_v[0] || we_v[0] || done_v[0]) act++;
        end
        n_chk++;
        if (act !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: got %0d active cycles, want 0", act);
        end
        run_layer(0, "after_reset", 1'b0, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        randomize_mem(0);
        run_layer(0, "b2b_first", 1'b0, -1, 1'b1);
        run_layer(0, "b2b_second", 1'b1, -1, 1'b0);
        randomize_mem(1);
        run_layer(1, "b2b1_first", 1'b0, -1, 1'b1);
        run_layer(1, "b2b1_second", 1'b1, -1, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        st  = 2'b00;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) mem_in[k][i] = '0;
            for (int i = 0; i < 8; i++) mem_w[k][i]  = '0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_directed();
        test_random();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
